inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Initiator side of the instruction-ROM interface. Holds the program counter and drives the ROM chip-enable and byte address. Registers the combinational ROM read data, with its PC, into the IF/ID stage outputs. Handles the pipeline stall vector and taken-branch redirects from decode, and keeps a retired-fetch counter for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
STALL_W, 6, width of the pipeline stall vector. Bit 0 = PC, bit 1 = IF, bit 2 = ID.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
stall  input  STALL_W  pipeline stall vector from ctrl.
branch_flag_i  input  1  decode reports a taken branch/jump.
branch_target_address_i  input  32  byte address of the branch target.
rom_ce_o  output  1  ROM chip-enable (ReadEnable=1).
rom_addr_o  output  32  ROM byte address; always word-aligned.
rom_inst_i  input  32  ROM read data, combinational from rom_addr_o/rom_ce_o.
id_pc_o  output  32  PC of the instruction presented to decode.
id_inst_o  output  32  instruction presented to decode.
fetch_cnt_o  output  32  count of instructions delivered to decode.

Behaviour:
- Reset (rst=0, asynchronous, overrides everything):
  - pc=RESET_PC, rom_ce_o=0, id_pc_o=0, id_inst_o=0, fetch_cnt_o=0.
  - State goes to BOOT.
- State machine, 2 states:
  - BOOT: rom_ce_o=0 and pc is held. On the first rising edge after rst deasserts: rom_ce_o<=1, pc remains RESET_PC, go to RUN.
  - RUN: rom_ce_o=1. Stays in RUN until reset.
- PC update in RUN, priority order:
  - stall[0]=1: pc holds. A simultaneous branch_flag_i is ignored; decode re-asserts it while stalled.
  - else if branch_flag_i=1: pc<=branch_target_address_i with bits[1:0] forced to 2'b00.
  - else: pc<=pc+4. Modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- rom_addr_o=pc and rom_ce_o=state==RUN, both straight from registers.
- Instruction latency: ROM data is combinational. An instruction whose PC appears on rom_addr_o in cycle N is on id_pc_o/id_inst_o after the edge ending cycle N, i.e. 1 cycle.
- Branch delay slot:
  - The instruction already in IF when branch_flag_i is sampled is passed to decode normally. No flush.
  - The target is fetched in the next cycle.
- IF/ID register, evaluated each rising edge:
  - rom_ce_o=0: id_pc_o<=0, id_inst_o<=0.
  - else if stall[1]=1 and stall[2]=0: bubble, id_pc_o<=0, id_inst_o<=0.
  - else if stall[1]=0: id_pc_o<=pc, id_inst_o<=rom_inst_i.
  - else (stall[1]=1, stall[2]=1): hold.
- fetch_cnt_o increments by 1 on each edge where the IF/ID register captures (rom_ce_o=1 and stall[1]=0). It wraps at 2^32 and never increments on bubble or hold.
- Reset mid-operation: all state is cleared immediately. After release, one BOOT cycle, then fetch restarts at RESET_PC.

Test Plan:
- Reset/boot: hold rst=0 for 3 cycles, then release. Required: cycle 0 after release rom_ce_o=0; cycle 1 rom_ce_o=1, rom_addr_o=0x0; then 0x4, 0x8. After the 3rd RUN edge id_pc_o=0x4 and id_inst_o=rom[1].
- Taken branch: at rom_addr_o=0x8 assert branch_flag_i=1 with target 0x40 for 1 cycle. Required: rom_addr_o sequence 0x8, 0x40, 0x44. id_pc_o sequence 0x4, 0x8 (delay slot), 0x40. fetch_cnt_o keeps counting with no gap.
- Misaligned target: branch to 0x43. Required: rom_addr_o=0x40.
- Stall hold: stall=6'b000111 for 2 cycles at pc=0x10. Required: rom_addr_o holds 0x10, id_pc_o/id_inst_o hold, fetch_cnt_o unchanged. On release, fetch resumes at 0x14.
- Bubble plus stall/branch collision: stall=6'b000011 together with branch_flag_i=1 (target 0x80) for 1 cycle. Required: id outputs go to 0, pc holds, branch is ignored. Re-assert the branch with stall=0: rom_addr_o=0x80.
- Wrap and async reset: force pc to 0xFFFF_FFFC, then free run. Required: next rom_addr_o=0x0. Pulse rst low mid-cycle. Required: all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and registers
// the fetched word with its PC into the IF/ID outputs.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_target_address_i,
  output logic               rom_ce_o,
  output logic [31:0]        rom_addr_o,
  input  logic [31:0]        rom_inst_i,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_inst_o,
  output logic [31:0]        fetch_cnt_o
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_id_pc, w_id_pc_d;
  logic [31:0] r_id_inst, w_id_inst_d;
  logic [31:0] r_fetch_cnt, w_fetch_cnt_d;
  logic        w_stall_pc, w_stall_if, w_stall_id;
  logic        w_unused_stall;

  assign w_stall_pc     = stall[0];
  assign w_stall_if     = stall[1];
  assign w_stall_id     = stall[2];
  // Later pipeline stages share the vector but do not affect fetch.
  assign w_unused_stall = ^stall[STALL_W-1:3];

  assign rom_ce_o    = (r_state == ST_RUN);
  assign rom_addr_o  = r_pc;
  assign id_pc_o     = r_id_pc;
  assign id_inst_o   = r_id_inst;
  assign fetch_cnt_o = r_fetch_cnt;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    if (r_state == ST_BOOT) begin
      w_state_d = ST_RUN;
    end else if (w_stall_pc) begin
      // Decode re-asserts a branch that collides with a PC stall.
      w_pc_d = r_pc;
    end else if (branch_flag_i) begin
      w_pc_d = {branch_target_address_i[31:2], 2'b00};
    end else begin
      w_pc_d = r_pc + 32'd4;
    end
  end

  always_comb begin
    w_id_pc_d     = r_id_pc;
    w_id_inst_d   = r_id_inst;
    w_fetch_cnt_d = r_fetch_cnt;
    if (!rom_ce_o) begin
      w_id_pc_d   = 32'd0;
      w_id_inst_d = 32'd0;
    end else if (w_stall_if && !w_stall_id) begin
      w_id_pc_d   = 32'd0;
      w_id_inst_d = 32'd0;
    end else if (!w_stall_if) begin
      w_id_pc_d     = r_pc;
      w_id_inst_d   = rom_inst_i;
      w_fetch_cnt_d = r_fetch_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_id_pc     <= 32'd0;
      r_id_inst   <= 32'd0;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_id_pc     <= w_id_pc_d;
      r_id_inst   <= w_id_inst_d;
      r_fetch_cnt <= w_fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, branches, stalls, bubbles, PC wrap and async reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [31:0] fetch_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .STALL_W (6)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .rom_ce_o               (rom_ce_o),
    .rom_addr_o             (rom_addr_o),
    .rom_inst_i             (rom_inst_i),
    .id_pc_o                (id_pc_o),
    .id_inst_o              (id_inst_o),
    .fetch_cnt_o            (fetch_cnt_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic ce, input logic [31:0] addr,
                           input logic [31:0] ipc, input logic [31:0] cnt);
    check({tag, " ce"}, {31'd0, rom_ce_o}, {31'd0, ce});
    check({tag, " addr"}, rom_addr_o, addr);
    check({tag, " id_pc"}, id_pc_o, ipc);
    check({tag, " id_inst"}, id_inst_o, (ipc == 32'd0 && cnt == 32'd0) ? 32'd0 : rom_word(ipc));
    check({tag, " cnt"}, fetch_cnt_o, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    stall = 6'd0;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'd0;

    // Reset and boot
    #2;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check({"boot0 ce"}, {31'd0, rom_ce_o}, 32'd0);
    tick();
    check_all("run1", 1'b1, 32'h0, 32'h0, 32'd0);
    tick();
    check_all("run2", 1'b1, 32'h4, 32'h0, 32'd1);
    tick();
    check_all("run3", 1'b1, 32'h8, 32'h4, 32'd2);

    // Taken branch with delay slot
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h40;
    tick();
    branch_flag_i = 1'b0;
    check_all("br tgt", 1'b1, 32'h40, 32'h8, 32'd3);
    tick();
    check_all("br next", 1'b1, 32'h44, 32'h40, 32'd4);

    // Misaligned target
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h43;
    tick();
    branch_flag_i = 1'b0;
    check_all("misalign", 1'b1, 32'h40, 32'h44, 32'd5);
    tick();
    check_all("misalign next", 1'b1, 32'h44, 32'h40, 32'd6);

    // Stall hold at pc 0x10
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h10;
    tick();
    branch_flag_i = 1'b0;
    check_all("to 0x10", 1'b1, 32'h10, 32'h44, 32'd7);
    stall = 6'b000111;
    tick();
    check_all("hold1", 1'b1, 32'h10, 32'h44, 32'd7);
    tick();
    check_all("hold2", 1'b1, 32'h10, 32'h44, 32'd7);
    stall = 6'b000000;
    tick();
    check_all("resume", 1'b1, 32'h14, 32'h10, 32'd8);

    // Bubble with colliding branch
    stall = 6'b000011;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h80;
    tick();
    check({"bubble addr"}, rom_addr_o, 32'h14);
    check({"bubble id_pc"}, id_pc_o, 32'h0);
    check({"bubble id_inst"}, id_inst_o, 32'h0);
    check({"bubble cnt"}, fetch_cnt_o, 32'd8);
    stall = 6'b000000;
    tick();
    branch_flag_i = 1'b0;
    check_all("rebranch", 1'b1, 32'h80, 32'h14, 32'd9);
    tick();
    check_all("rebranch next", 1'b1, 32'h84, 32'h80, 32'd10);

    // PC wrap
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 1'b0;
    check_all("pc top", 1'b1, 32'hFFFF_FFFC, 32'h84, 32'd11);
    tick();
    check_all("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'd12);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1;
    check_all("async rst", 1'b0, 32'h0, 32'h0, 32'd0);
    tick();
    rst = 1'b1;
    check({"reboot0 ce"}, {31'd0, rom_ce_o}, 32'd0);
    tick();
    check_all("rerun1", 1'b1, 32'h0, 32'h0, 32'd0);
    tick();
    check_all("rerun2", 1'b1, 32'h4, 32'h0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
